// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types, defaults and data function for the RAM BIST master
//
// Purpose: state encoding, default geometry/latency and the D(a) data function
// used by ram_bist_master and ram_bist_cmp.
package ram_bist_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0,
    W1,
    R1,
    DRAIN,
    DONE
  } bist_state_e;

  // D(a) = P ^ a[DATA_W-1:0] ^ a[ADDR_W-1:DATA_W]. The upper address bits are
  // folded into the low lanes so that two aliased addresses never share data.
  // Callers truncate the 32-bit result to DATA_W.
  function automatic logic [31:0] bist_data(input logic [31:0] p,
                                            input logic [31:0] a,
                                            input int unsigned addr_w,
                                            input int unsigned data_w);
    logic [31:0] mask;
    logic [31:0] lo;
    logic [31:0] hi;
    mask = (32'd1 << data_w) - 32'd1;
    lo   = a & mask;
    hi   = (a & ((32'd1 << addr_w) - 32'd1)) >> data_w;
    return (p ^ lo ^ hi) & mask;
  endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// rtl/ram_bist_cmp.sv - read-return pipeline, compare, error count and first-fail capture
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           clear error count and first-fail record (test start)
//   issue_i         a read is being launched on the RAM port this edge
//   addr_i, exp_i   address and expected data of that read
//   rdata_i         RAM read data, sampled RD_LAT edges after launch
//   err_count_o     miscompare count
//   fail_addr_o     address of the first miscompare
//   fail_data_o     data read at the first miscompare
module ram_bist_cmp
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [ADDR_W+1:0] err_count_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [DATA_W-1:0] fail_data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] addr_q [RD_LAT];
  logic [DATA_W-1:0] exp_q  [RD_LAT];

  logic [ADDR_W+1:0] err_q, err_d;
  logic [ADDR_W-1:0] faddr_q, faddr_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic              miss;

  // Stage 0 is loaded on the same edge that drives the read onto the RAM
  // port, so the last stage lines up with the edge where rdata is valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int j = 0; j < RD_LAT; j++) begin
        addr_q[j] <= '0;
        exp_q[j]  <= '0;
      end
    end else begin
      vld_q[0]  <= issue_i;
      addr_q[0] <= addr_i;
      exp_q[0]  <= exp_i;
      for (int j = 1; j < RD_LAT; j++) begin
        vld_q[j]  <= vld_q[j-1];
        addr_q[j] <= addr_q[j-1];
        exp_q[j]  <= exp_q[j-1];
      end
    end
  end

  assign miss = vld_q[RD_LAT-1] && (rdata_i != exp_q[RD_LAT-1]);

  always_comb begin
    err_d   = err_q;
    faddr_d = faddr_q;
    fdata_d = fdata_q;
    if (clr_i) begin
      err_d   = '0;
      faddr_d = '0;
      fdata_d = '0;
    end else if (miss) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) begin
        faddr_d = addr_q[RD_LAT-1];
        fdata_d = rdata_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q   <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
    end else begin
      err_q   <= err_d;
      faddr_q <= faddr_d;
      fdata_q <= fdata_d;
    end
  end

  assign err_count_o = err_q;
  assign fail_addr_o = faddr_q;
  assign fail_data_o = fdata_q;

endmodule

// File: rtl/ram_bist_master.sv
// rtl/ram_bist_master.sv - four-phase march BIST engine for a single-port RAM
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, pattern    test request (IDLE/DONE only) and seed pattern P
//   busy, done, pass  run status; pass valid while done
//   err_count         miscompare count
//   fail_addr/_data   first miscompare location and the data read there
//   mem_en, mem_rw    RAM enable, 1 = read / 0 = write (registered)
//   mem_addr, mem_wdata RAM address and write data (registered)
//   mem_rdata         RAM read data
module ram_bist_master
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W+1:0] err_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] DRAIN_END = ADDR_W'(RD_LAT - 1);

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              clr;
  logic              wr_d;
  logic              rd_d;
  logic [DATA_W-1:0] dat_d;
  logic [DATA_W-1:0] exp_d;

  // state_q/addr_q describe the access currently on the RAM port; the RAM
  // outputs are registered from the next-state values so they change together.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pat_d   = pat_q;
    clr     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = W0;
          addr_d  = '0;
          pat_d   = pattern;
          clr     = 1'b1;
        end
      end
      W0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = R0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      R0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = W1;
          addr_d  = ADDR_MAX;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      W1: begin
        if (addr_q == '0) begin
          state_d = R1;
          addr_d  = ADDR_MAX;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      R1: begin
        if (addr_q == '0) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      // The address counter doubles as the drain timer: no RAM access here.
      DRAIN: begin
        if (addr_q == DRAIN_END) begin
          state_d = DONE;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d  = (state_d == W0) || (state_d == W1);
    rd_d  = (state_d == R0) || (state_d == R1);
    dat_d = DATA_W'(bist_data(32'(pat_d), 32'(addr_d), ADDR_W, DATA_W));
    exp_d = (state_d == R1) ? ~dat_d : dat_d;

    mem_en_d    = wr_d || rd_d;
    mem_rw_d    = !wr_d;
    mem_addr_d  = (wr_d || rd_d) ? addr_d : mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_d == W0) mem_wdata_d = dat_d;
    if (state_d == W1) mem_wdata_d = ~dat_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      pat_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pat_q       <= pat_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  ram_bist_cmp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .issue_i     (rd_d),
    .addr_i      (addr_d),
    .exp_i       (exp_d),
    .rdata_i     (mem_rdata),
    .err_count_o (err_count),
    .fail_addr_o (fail_addr),
    .fail_data_o (fail_data)
  );

  assign busy      = (state_q == W0) || (state_q == R0) || (state_q == W1) ||
                     (state_q == R1) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_count == '0);
  assign mem_en    = mem_en_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ram_bist_master.sv
// tb/tb_ram_bist_master.sv - directed self-checking bench for ram_bist_master
module tb_ram_bist_master;

  logic       clk;
  logic       rst_n;
  int         cyc;
  int         n_chk;
  int         n_pass;

  // DUT 1: RD_LAT=1 with an asynchronous-read RAM model
  logic       d1_start, d1_busy, d1_done, d1_pass, d1_en, d1_rw;
  logic [3:0] d1_pattern, d1_fdata, d1_wdata, d1_rdata;
  logic [7:0] d1_err;
  logic [5:0] d1_faddr, d1_addr;
  // DUT 3: RD_LAT=3 with a three-cycle RAM model
  logic       d3_start, d3_busy, d3_done, d3_pass, d3_en, d3_rw;
  logic [3:0] d3_pattern, d3_fdata, d3_wdata, d3_rdata;
  logic [7:0] d3_err;
  logic [5:0] d3_faddr, d3_addr;

  ram_bist_master #(.ADDR_W(6), .DATA_W(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(d1_start), .pattern(d1_pattern),
    .busy(d1_busy), .done(d1_done), .pass(d1_pass), .err_count(d1_err),
    .fail_addr(d1_faddr), .fail_data(d1_fdata), .mem_en(d1_en), .mem_rw(d1_rw),
    .mem_addr(d1_addr), .mem_wdata(d1_wdata), .mem_rdata(d1_rdata)
  );

  ram_bist_master #(.ADDR_W(6), .DATA_W(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(d3_start), .pattern(d3_pattern),
    .busy(d3_busy), .done(d3_done), .pass(d3_pass), .err_count(d3_err),
    .fail_addr(d3_faddr), .fail_data(d3_fdata), .mem_en(d3_en), .mem_rw(d3_rw),
    .mem_addr(d3_addr), .mem_wdata(d3_wdata), .mem_rdata(d3_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] dfn(input logic [3:0] p, input logic [5:0] a);
    return p ^ a[3:0] ^ {2'b00, a[5:4]};
  endfunction

  // RAM 1: mode 0 ideal, 1 = addr 5 bit0 stuck-at-1, 2 = address bit5 ignored
  logic [3:0] mem1 [64];
  int         mode1;
  logic [5:0] eff1;
  always_comb begin
    eff1 = (mode1 == 2) ? {1'b0, d1_addr[4:0]} : d1_addr;
    d1_rdata = mem1[eff1];
    if (mode1 == 1 && d1_addr == 6'd5) d1_rdata = mem1[eff1] | 4'h1;
  end
  always @(posedge clk) if (d1_en && !d1_rw) mem1[eff1] <= d1_wdata;

  // RAM 3: two registers behind an asynchronous read; mode 3 corrupts the
  // W1-phase write to address 63 (the first write there after 64 writes)
  logic [3:0] mem3 [64];
  logic [3:0] r3a, r3b;
  int         mode3;
  int         wcnt3;
  always @(posedge clk) begin
    if (d3_start && !d3_busy) wcnt3 <= 0;
    else if (d3_en && !d3_rw) wcnt3 <= wcnt3 + 1;
    if (d3_en && !d3_rw)
      mem3[d3_addr] <= (mode3 == 3 && d3_addr == 6'd63 && wcnt3 >= 64) ? (d3_wdata ^ 4'h1) : d3_wdata;
    r3a <= mem3[d3_addr];
    r3b <= r3a;
  end
  assign d3_rdata = r3b;

  // Access-order monitor for DUT 1, indexed from the snapshot base1
  int en_cnt1, base1, ord_err1, en_cnt3;
  int idx, ph, ii;
  logic [5:0] exp_a;
  initial begin en_cnt1 = 0; ord_err1 = 0; en_cnt3 = 0; end
  always @(negedge clk) begin
    if (d1_en) begin
      idx = en_cnt1 - base1;
      ph  = idx / 64;
      ii  = idx % 64;
      exp_a = (ph < 2) ? 6'(ii) : 6'(63 - ii);
      if (d1_rw !== ph[0] || d1_addr !== exp_a) ord_err1 = ord_err1 + 1;
      else if (!d1_rw && d1_wdata !== ((ph == 0) ? dfn(d1_pattern, exp_a) : ~dfn(d1_pattern, exp_a)))
        ord_err1 = ord_err1 + 1;
      en_cnt1 = en_cnt1 + 1;
    end
    if (d3_en) en_cnt3 = en_cnt3 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Starts a run on DUT 1 or 3, checks the cleared status one cycle later and
  // returns edges from start sampling to done (-1 if done never rose).
  task automatic run(input int which, input logic [3:0] p, input bit pulses, output int lat);
    int s;
    @(negedge clk);
    if (which == 1) begin d1_start = 1'b1; d1_pattern = p; base1 = en_cnt1; end
    else begin d3_start = 1'b1; d3_pattern = p; end
    @(posedge clk);
    #1 s = cyc;
    @(negedge clk);
    d1_start = 1'b0;
    d3_start = 1'b0;
    check_eq("start_busy", (which == 1) ? d1_busy : d3_busy, 1);
    check_eq("start_clr", (which == 1) ? {d1_done, d1_err} : {d3_done, d3_err}, 0);
    lat = -1;
    for (int n = 0; n < 400; n++) begin
      if ((which == 1) ? d1_done : d3_done) begin
        lat = cyc - s;
        break;
      end
      if (pulses) d1_start = (cyc - s == 10) || (cyc - s == 100);
      @(negedge clk);
    end
    d1_start = 1'b0;
  endtask

  int lat, e0, o0;

  initial begin
    n_chk = 0; n_pass = 0;
    mode1 = 0; mode3 = 0; base1 = 0;
    d1_start = 0; d3_start = 0; d1_pattern = 0; d3_pattern = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_status", {d1_busy, d1_done, d1_pass}, 0);
    check_eq("rst_err", {d1_err, d1_faddr, d1_fdata}, 0);
    check_eq("rst_mem_ctl", {d1_en, d1_rw}, 2'b01);
    check_eq("rst_mem_bus", {d1_addr, d1_wdata}, 0);
    rst_n = 1'b1;

    // ideal RAM, P=A
    e0 = en_cnt1; o0 = ord_err1;
    run(1, 4'hA, 1'b0, lat);
    check_eq("ideal_lat", lat, 257);
    check_eq("ideal_pass", d1_pass, 1);
    check_eq("ideal_err", d1_err, 0);
    check_eq("ideal_en_cycles", en_cnt1 - e0, 256);
    check_eq("ideal_order", ord_err1 - o0, 0);

    // address 5 bit0 stuck-at-1, P=0
    mode1 = 1;
    run(1, 4'h0, 1'b0, lat);
    check_eq("stuck_lat", lat, 257);
    check_eq("stuck_err", d1_err, 1);
    check_eq("stuck_faddr", d1_faddr, 5);
    check_eq("stuck_fdata", d1_fdata, 4'hB);
    check_eq("stuck_pass", d1_pass, 0);

    // address bit5 ignored, P=0
    mode1 = 2;
    run(1, 4'h0, 1'b0, lat);
    check_eq("alias_err", d1_err, 64);
    check_eq("alias_faddr", d1_faddr, 0);
    check_eq("alias_fdata", d1_fdata, 4'h2);
    check_eq("alias_pass", d1_pass, 0);

    // rerun from DONE with ignored start pulses mid-run
    mode1 = 0; o0 = ord_err1; e0 = en_cnt1;
    run(1, 4'h3, 1'b1, lat);
    check_eq("pulse_lat", lat, 257);
    check_eq("pulse_pass", d1_pass, 1);
    check_eq("pulse_en_cycles", en_cnt1 - e0, 256);
    check_eq("pulse_order", ord_err1 - o0, 0);

    // asynchronous reset in the middle of R0
    @(negedge clk);
    d1_start = 1'b1; d1_pattern = 4'h5; base1 = en_cnt1;
    @(negedge clk);
    d1_start = 1'b0;
    repeat (99) @(negedge clk);
    check_eq("pre_rst_busy", d1_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_status", {d1_busy, d1_done, d1_pass, d1_err}, 0);
    check_eq("midrst_mem", {d1_en, d1_rw, d1_addr, d1_wdata}, 12'h400);
    @(negedge clk);
    rst_n = 1'b1;
    o0 = ord_err1;
    run(1, 4'h5, 1'b0, lat);
    check_eq("after_rst_lat", lat, 257);
    check_eq("after_rst_pass", d1_pass, 1);
    check_eq("after_rst_order", ord_err1 - o0, 0);

    // RD_LAT=3
    e0 = en_cnt3;
    run(3, 4'hA, 1'b0, lat);
    check_eq("lat3_lat", lat, 259);
    check_eq("lat3_pass", d3_pass, 1);
    check_eq("lat3_en_cycles", en_cnt3 - e0, 256);
    mode3 = 3;
    run(3, 4'hA, 1'b0, lat);
    check_eq("lat3f_lat", lat, 259);
    check_eq("lat3f_err", d3_err, 1);
    check_eq("lat3f_faddr", d3_faddr, 63);
    check_eq("lat3f_fdata", d3_fdata, 4'h8);
    check_eq("lat3f_pass", d3_pass, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
